// File: rtl/hex_counter_n.sv
// Multi-digit cascaded counter in a configurable radix with up/down, hold, preset
// load, wrap/zero flags and seven-segment decode with optional leading-zero blanking.
module hex_counter_n #(
  parameter int          DIGITS   = 4,
  parameter int          RADIX    = 16,
  parameter logic [31:0] PRESET   = 32'h0,
  parameter int          BLANK_LZ = 0
) (
  input  logic [2:0]          KEY,
  input  logic [3:0]          SW,
  output logic [8*DIGITS-1:0] HEX,
  output logic [1:0]          LEDR
);

  localparam logic [3:0] DMAX = 4'(RADIX - 1);

  logic       clk;
  logic       rst;
  logic       dir_down;
  logic       hold;
  logic       load;
  logic       unused_key;

  assign clk        = KEY[2];
  assign unused_key = ^KEY[1:0];
  assign rst        = SW[0];
  assign dir_down   = SW[1];
  assign hold       = SW[2];
  assign load       = SW[3];

  logic [3:0] digits_q [DIGITS];
  logic [3:0] digits_d [DIGITS];
  logic       wrap_q;
  logic       wrap_d;
  logic       carry;
  logic [3:0] pdig;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      4'hF:    s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // carry doubles as borrow; it survives the loop only if every digit rolled over
  always_comb begin
    wrap_d = 1'b0;
    carry  = 1'b1;
    pdig   = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      digits_d[i] = digits_q[i];
    end
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        pdig        = PRESET[4*i +: 4];
        digits_d[i] = (pdig > DMAX) ? DMAX : pdig;
      end
    end else if (!hold) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (dir_down) begin
            if (digits_q[i] == 4'h0) begin
              digits_d[i] = DMAX;
            end else begin
              digits_d[i] = digits_q[i] - 4'h1;
              carry       = 1'b0;
            end
          end else begin
            if (digits_q[i] == DMAX) begin
              digits_d[i] = 4'h0;
            end else begin
              digits_d[i] = digits_q[i] + 4'h1;
              carry       = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        digits_q[i] <= 4'h0;
      end
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        digits_q[i] <= digits_d[i];
      end
      wrap_q <= wrap_d;
    end
  end

  // lz[i] is set when digit i and every digit above it are zero
  logic [DIGITS-1:0] lz;

  always_comb begin
    lz               = '0;
    lz[DIGITS-1]     = (digits_q[DIGITS-1] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (digits_q[i] == 4'h0);
    end
  end

  always_comb begin
    HEX = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((BLANK_LZ != 0) && (i > 0) && lz[i]) begin
        HEX[8*i +: 8] = 8'hFF;
      end else begin
        HEX[8*i +: 8] = seg7(digits_q[i]);
      end
    end
  end

  assign LEDR = {lz[0], wrap_q};

endmodule

// File: tb/tb_hex_counter_n.sv
// Scoreboard bench: the driver queues hand-computed expectations per edge, the monitor
// pops one entry after every rising edge and compares against the selected instance.
module tb_hex_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  sw_v [5];
  logic [31:0] u0_hex;
  logic [15:0] u1_hex;
  logic [15:0] u2_hex;
  logic [31:0] u3_hex;
  logic [31:0] u4_hex;
  logic [1:0]  u0_ledr, u1_ledr, u2_ledr, u3_ledr, u4_ledr;

  hex_counter_n #(.DIGITS(4), .RADIX(16), .PRESET(32'h0), .BLANK_LZ(0)) u0 (
    .KEY({clk, 2'b00}), .SW(sw_v[0]), .HEX(u0_hex), .LEDR(u0_ledr));
  hex_counter_n #(.DIGITS(2), .RADIX(10), .PRESET(32'h0), .BLANK_LZ(0)) u1 (
    .KEY({clk, 2'b00}), .SW(sw_v[1]), .HEX(u1_hex), .LEDR(u1_ledr));
  hex_counter_n #(.DIGITS(2), .RADIX(16), .PRESET(32'h0), .BLANK_LZ(0)) u2 (
    .KEY({clk, 2'b00}), .SW(sw_v[2]), .HEX(u2_hex), .LEDR(u2_ledr));
  hex_counter_n #(.DIGITS(4), .RADIX(10), .PRESET(32'h0F37), .BLANK_LZ(0)) u3 (
    .KEY({clk, 2'b00}), .SW(sw_v[3]), .HEX(u3_hex), .LEDR(u3_ledr));
  hex_counter_n #(.DIGITS(4), .RADIX(16), .PRESET(32'h0), .BLANK_LZ(1)) u4 (
    .KEY({clk, 2'b00}), .SW(sw_v[4]), .HEX(u4_hex), .LEDR(u4_ledr));

  typedef struct {
    int          id;
    logic [31:0] hex;
    logic [1:0]  ledr;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic step(input int id, input logic [3:0] sw, input bit chk,
                      input logic [31:0] hex, input logic [1:0] ledr, input string name);
    exp_t e;
    @(negedge clk);
    sw_v[id] = sw;
    e.id   = id;
    e.hex  = hex;
    e.ledr = ledr;
    e.chk  = chk;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ah;
    logic [1:0]  al;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          case (e.id)
            0:       begin ah = u0_hex;          al = u0_ledr; end
            1:       begin ah = {16'h0, u1_hex}; al = u1_ledr; end
            2:       begin ah = {16'h0, u2_hex}; al = u2_ledr; end
            3:       begin ah = u3_hex;          al = u3_ledr; end
            default: begin ah = u4_hex;          al = u4_ledr; end
          endcase
          n_cmp++;
          if (ah !== e.hex || al !== e.ledr) begin
            n_err++;
            $display("FAIL %s: got HEX=%h LEDR=%b, expected HEX=%h LEDR=%b",
                     e.name, ah, al, e.hex, e.ledr);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) sw_v[i] = 4'b0001;

    // u0: DIGITS=4 RADIX=16
    step(0, 4'b0001, 1, 32'hC0C0C0C0, 2'b10, "u0 reset");
    step(0, 4'b0000, 1, 32'hC0C0C0F9, 2'b00, "u0 up 1");
    step(0, 4'b0000, 1, 32'hC0C0C0A4, 2'b00, "u0 up 2");
    step(0, 4'b0000, 1, 32'hC0C0C0B0, 2'b00, "u0 up 3");
    for (int i = 4; i <= 66; i++)
      step(0, 4'b0000, (i == 16), 32'hC0C0F9C0, 2'b00, "u0 carry 0010");
    step(0, 4'b0100, 1, 32'hC0C099A4, 2'b00, "u0 hold at 0042");
    step(0, 4'b1111, 1, 32'hC0C0C0C0, 2'b10, "u0 reset priority");
    step(0, 4'b0001, 1, 32'hC0C0C0C0, 2'b10, "u0 reset held");
    step(0, 4'b0010, 1, 32'h8E8E8E8E, 2'b01, "u0 down wrap");
    step(0, 4'b0010, 1, 32'h8E8E8E86, 2'b00, "u0 down FFFE");
    step(0, 4'b0100, 1, 32'h8E8E8E86, 2'b00, "u0 hold FFFE");
    step(0, 4'b0000, 1, 32'h8E8E8E8E, 2'b00, "u0 dir change up");
    step(0, 4'b0000, 1, 32'hC0C0C0C0, 2'b11, "u0 up wrap");

    // u1: DIGITS=2 RADIX=10
    step(1, 4'b0001, 1, 32'hC0C0, 2'b10, "u1 reset");
    for (int i = 1; i <= 99; i++)
      step(1, 4'b0000, (i == 9 || i == 10 || i == 99),
           (i == 9) ? 32'hC090 : (i == 10) ? 32'hF9C0 : 32'h9090, 2'b00, "u1 bcd count");
    step(1, 4'b0000, 1, 32'hC0C0, 2'b11, "u1 bcd wrap");
    step(1, 4'b0000, 1, 32'hC0F9, 2'b00, "u1 after wrap");

    // u2: DIGITS=2 RADIX=16, alternating direction gives back-to-back wraps
    step(2, 4'b0001, 1, 32'hC0C0, 2'b10, "u2 reset");
    step(2, 4'b0010, 1, 32'h8E8E, 2'b01, "u2 down wrap");
    step(2, 4'b0010, 1, 32'h8E86, 2'b00, "u2 down FE");
    step(2, 4'b0000, 1, 32'h8E8E, 2'b00, "u2 up FF");
    step(2, 4'b0000, 1, 32'hC0C0, 2'b11, "u2 up wrap");
    step(2, 4'b0010, 1, 32'h8E8E, 2'b01, "u2 consecutive wrap dn");
    step(2, 4'b0000, 1, 32'hC0C0, 2'b11, "u2 consecutive wrap up");

    // u3: DIGITS=4 RADIX=10 PRESET=0F37
    step(3, 4'b0001, 1, 32'hC0C0C0C0, 2'b10, "u3 reset");
    step(3, 4'b1100, 1, 32'hC090B0F8, 2'b00, "u3 load clamp over hold");
    step(3, 4'b0100, 1, 32'hC090B0F8, 2'b00, "u3 hold 1");
    step(3, 4'b0100, 1, 32'hC090B0F8, 2'b00, "u3 hold 2");
    step(3, 4'b0000, 1, 32'hC090B080, 2'b00, "u3 up 0938");
    step(3, 4'b0000, 1, 32'hC090B090, 2'b00, "u3 up 0939");
    step(3, 4'b0000, 1, 32'hC09099C0, 2'b00, "u3 up 0940");
    step(3, 4'b1010, 1, 32'hC090B0F8, 2'b00, "u3 load over down");

    // u4: DIGITS=4 RADIX=16 BLANK_LZ=1
    step(4, 4'b0001, 1, 32'hFFFFFFC0, 2'b10, "u4 reset blank");
    for (int i = 1; i <= 18; i++)
      step(4, 4'b0000, (i == 1 || i == 16 || i == 18),
           (i == 1) ? 32'hFFFFFFF9 : (i == 16) ? 32'hFFFFF9C0 : 32'hFFFFF9A4,
           2'b00, "u4 blank count");
    step(4, 4'b0001, 1, 32'hFFFFFFC0, 2'b10, "u4 reset again");
    step(4, 4'b0010, 1, 32'h8E8E8E8E, 2'b01, "u4 down wrap no blank");
    step(4, 4'b0000, 1, 32'hFFFFFFC0, 2'b11, "u4 up wrap blank");

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
